fft_frame_feeder: RTL and testbench

- Downstream stage of the checkFFT AXI4-Lite register slave. Consumes the slave's per-register write strobes: sample writes to reg0, control writes to reg1.
- Buffers CPU-written 32-bit samples in a FIFO. On a start command, emits exactly one frame of FRAME_LEN samples as an AXI4-Stream master toward the FFT core, with TLAST on the final beat.
- Returns status (fill level, busy, done, overflow, length error) for the slave's read-back registers (reg2/reg3).

---
 rtl/fft_frame_feeder.sv | 248 ++++++++++++++++++++++++
 tb/tb_fft_frame_feeder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: buffers CPU-written samples in a FIFO and, on a start
// command, streams exactly one frame of the requested length as an
// AXI4-Stream master. TLAST marks the final beat. Status for read-back:
// fill level, busy, a done pulse, and sticky overflow / bad-length flags.

// Protocol checker, instantiated by the top. It holds assertions only.
module fft_frame_feeder_checker #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 7
) (
  input logic              ACLK,
  input logic              ARESETN,
  input logic              ctl_clear,
  input logic [DATA_W-1:0] m_axis_tdata,
  input logic              m_axis_tvalid,
  input logic              m_axis_tready,
  input logic              m_axis_tlast,
  input logic [CNT_W-1:0]  sts_count,
  input logic              sts_busy
);

  // A stalled beat keeps its payload until it is accepted or flushed.
  a_stall_stable: assert property (@(posedge ACLK) disable iff (!ARESETN)
    (m_axis_tvalid && !m_axis_tready && !ctl_clear) |=>
      (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast)));

  // Valid data can only be presented while a frame is in progress.
  a_valid_busy: assert property (@(posedge ACLK) disable iff (!ARESETN)
    m_axis_tvalid |-> sts_busy);

  // Occupancy never exceeds the storage size.
  a_count_max: assert property (@(posedge ACLK) disable iff (!ARESETN)
    sts_count <= CNT_W'(DEPTH));

endmodule

module fft_frame_feeder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 7
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              smp_wr,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              ctl_start,
  input  logic              ctl_clear,
  input  logic [CNT_W-1:0]  ctl_len,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [CNT_W-1:0]  sts_count,
  output logic              sts_busy,
  output logic              sts_done,
  output logic              sts_ovf,
  output logic              sts_len_err
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Sample storage (no reset: contents are only visible through tvalid gating)
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             len_err_q, len_err_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] beats_q, beats_d;

  logic stream_valid;
  logic pop;
  logic push;
  logic len_ok;

  // The stream is valid purely from registered state, never from tready.
  assign stream_valid = (state_q == ST_STREAM) && (beats_q != ZERO_C);
  assign pop          = stream_valid && m_axis_tready;
  // A full FIFO still takes a write when a beat leaves in the same cycle.
  assign push         = smp_wr && !ctl_clear && ((count_q < DEPTH_C) || pop);
  assign len_ok       = (ctl_len != ZERO_C) && (ctl_len <= DEPTH_C);

  assign m_axis_tvalid = stream_valid;
  assign m_axis_tlast  = stream_valid && (beats_q == ONE_C);
  assign m_axis_tdata  = stream_valid ? mem_q[rd_ptr_q] : {DATA_W{1'b0}};
  assign sts_count     = count_q;
  assign sts_busy      = (state_q != ST_IDLE);
  assign sts_done      = (state_q == ST_DONE);
  assign sts_ovf       = ovf_q;
  assign sts_len_err   = len_err_q;

  // Next-state for FIFO pointers, occupancy and the overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (ctl_clear) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = ZERO_C;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      if (smp_wr && !push) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // Frame sequencing: length check, fill wait, beat countdown, done pulse.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beats_d   = beats_q;
    len_err_d = len_err_q;
    if (ctl_clear) begin
      state_d   = ST_IDLE;
      beats_d   = ZERO_C;
      len_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctl_start) begin
            if (len_ok) begin
              len_d   = ctl_len;
              beats_d = ctl_len;
              state_d = ST_FILL;
            end else begin
              len_err_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FILL: begin
          if (count_q >= len_q) begin
            state_d = ST_STREAM;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_STREAM: begin
          if (pop) begin
            beats_d = beats_q - ONE_C;
            if (beats_q == ONE_C) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_STREAM;
            end
          end else begin
            beats_d = beats_q;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sample write port into the storage array.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= smp_data;
    end
  end

  // FIFO and status registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= ZERO_C;
      ovf_q     <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      len_err_q <= len_err_d;
    end
  end

  // FSM state and frame length/beat registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      len_q   <= ZERO_C;
      beats_q <= ZERO_C;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beats_q <= beats_d;
    end
  end

  fft_frame_feeder_checker #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_checker (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .ctl_clear     (ctl_clear),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .sts_count     (sts_count),
    .sts_busy      (sts_busy)
  );

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed testbench for fft_frame_feeder. Each vector holds one cycle of
// inputs plus the outputs expected during that same cycle (before the edge
// that consumes those inputs).
module tb_fft_frame_feeder;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = 7;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic              smp_wr;
  logic [DATA_W-1:0] smp_data;
  logic              ctl_start;
  logic              ctl_clear;
  logic [CNT_W-1:0]  ctl_len;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [CNT_W-1:0]  sts_count;
  logic              sts_busy;
  logic              sts_done;
  logic              sts_ovf;
  logic              sts_len_err;

  typedef struct {
    logic              wr;
    logic [DATA_W-1:0] data;
    logic              start;
    logic              clr;
    logic [CNT_W-1:0]  len;
    logic              rdy;
    logic              e_valid;
    logic [DATA_W-1:0] e_data;
    logic              e_last;
    logic [CNT_W-1:0]  e_cnt;
    logic              e_busy;
    logic              e_done;
    logic              e_ovf;
    logic              e_lerr;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  fft_frame_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .smp_wr        (smp_wr),
    .smp_data      (smp_data),
    .ctl_start     (ctl_start),
    .ctl_clear     (ctl_clear),
    .ctl_len       (ctl_len),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .sts_count     (sts_count),
    .sts_busy      (sts_busy),
    .sts_done      (sts_done),
    .sts_ovf       (sts_ovf),
    .sts_len_err   (sts_len_err)
  );

  // 100 MHz clock.
  always #5 ACLK = ~ACLK;

  function automatic vec_t mk(
    input logic wr, input logic [DATA_W-1:0] data, input logic start,
    input logic clr, input logic [CNT_W-1:0] len, input logic rdy,
    input logic ev, input logic [DATA_W-1:0] ed, input logic el,
    input logic [CNT_W-1:0] ec, input logic eb, input logic edn,
    input logic eo, input logic ee);
    vec_t v;
    v.wr = wr; v.data = data; v.start = start; v.clr = clr; v.len = len; v.rdy = rdy;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_cnt = ec;
    v.e_busy = eb; v.e_done = edn; v.e_ovf = eo; v.e_lerr = ee;
    return v;
  endfunction

  // Drive one cycle of inputs, compare outputs mid-cycle, advance one edge.
  task automatic step(input vec_t v, input string tag);
    smp_wr        = v.wr;
    smp_data      = v.data;
    ctl_start     = v.start;
    ctl_clear     = v.clr;
    ctl_len       = v.len;
    m_axis_tready = v.rdy;
    #1;
    n_vec++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, sts_count, sts_busy, sts_done, sts_ovf, sts_len_err} !==
        {v.e_valid, v.e_data, v.e_last, v.e_cnt, v.e_busy, v.e_done, v.e_ovf, v.e_lerr}) begin
      n_bad++;
      $display("FAIL %s vec%0d: got v=%b d=%h l=%b c=%0d b=%b dn=%b o=%b le=%b want v=%b d=%h l=%b c=%0d b=%b dn=%b o=%b le=%b",
               tag, n_vec, m_axis_tvalid, m_axis_tdata, m_axis_tlast, sts_count, sts_busy, sts_done, sts_ovf, sts_len_err,
               v.e_valid, v.e_data, v.e_last, v.e_cnt, v.e_busy, v.e_done, v.e_ovf, v.e_lerr);
    end
    @(posedge ACLK);
    #1;
  endtask

  // Stimulus and checking.
  initial begin
    // Table: reset state, 4-sample frame at full rate, clear discarding wr/start.
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0,  1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h1, 1'b0, 1'b0, 7'd0, 1'b0,  1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h2, 1'b0, 1'b0, 7'd0, 1'b0,  1'b0, 32'h0, 1'b0, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h3, 1'b0, 1'b0, 7'd0, 1'b0,  1'b0, 32'h0, 1'b0, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h4, 1'b0, 1'b0, 7'd0, 1'b0,  1'b0, 32'h0, 1'b0, 7'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 7'd4, 1'b0,  1'b0, 32'h0, 1'b0, 7'd4, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1,  1'b0, 32'h0, 1'b0, 7'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1,  1'b1, 32'h1, 1'b0, 7'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1,  1'b1, 32'h2, 1'b0, 7'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1,  1'b1, 32'h3, 1'b0, 7'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1,  1'b1, 32'h4, 1'b1, 7'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0,  1'b0, 32'h0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0,  1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'hdead, 1'b1, 1'b1, 7'd1, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0,  1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    ARESETN = 1'b0; smp_wr = 1'b0; smp_data = 32'h0; ctl_start = 1'b0;
    ctl_clear = 1'b0; ctl_len = 7'd0; m_axis_tready = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;

    foreach (tbl[i]) step(tbl[i], "basic");

    // Frame of 8 started with only 3 samples held: waits in FILL.
    for (int i = 0; i < 3; i++)
      step(mk(1'b1, 32'h21 + 32'(i), 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'(i), 1'b0, 1'b0, 1'b0, 1'b0), "fill_push");
    step(mk(1'b0, 32'h0, 1'b1, 1'b0, 7'd8, 1'b0, 1'b0, 32'h0, 1'b0, 7'd3, 1'b0, 1'b0, 1'b0, 1'b0), "fill_start");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 32'h0, 1'b0, 7'd3, 1'b1, 1'b0, 1'b0, 1'b0), "fill_wait");
    for (int i = 3; i < 8; i++)
      step(mk(1'b1, 32'h21 + 32'(i), 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 32'h0, 1'b0, 7'(i), 1'b1, 1'b0, 1'b0, 1'b0), "fill_push2");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 32'h0, 1'b0, 7'd8, 1'b1, 1'b0, 1'b0, 1'b0), "fill_full");
    for (int k = 0; k < 8; k++)
      step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 32'h21 + 32'(k), (k == 7), 7'(8 - k), 1'b1, 1'b0, 1'b0, 1'b0), "fill_beat");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0), "fill_done");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0), "fill_idle");

    // Back-pressure: tready 1,0,0,1 then 1,1 over a 4-beat frame.
    for (int i = 0; i < 4; i++)
      step(mk(1'b1, 32'h31 + 32'(i), 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'(i), 1'b0, 1'b0, 1'b0, 1'b0), "stall_push");
    step(mk(1'b0, 32'h0, 1'b1, 1'b0, 7'd4, 1'b0, 1'b0, 32'h0, 1'b0, 7'd4, 1'b0, 1'b0, 1'b0, 1'b0), "stall_start");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd4, 1'b1, 1'b0, 1'b0, 1'b0), "stall_fill");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 32'h31, 1'b0, 7'd4, 1'b1, 1'b0, 1'b0, 1'b0), "stall_b1");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 32'h32, 1'b0, 7'd3, 1'b1, 1'b0, 1'b0, 1'b0), "stall_s1");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 32'h32, 1'b0, 7'd3, 1'b1, 1'b0, 1'b0, 1'b0), "stall_s2");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 32'h32, 1'b0, 7'd3, 1'b1, 1'b0, 1'b0, 1'b0), "stall_b2");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 32'h33, 1'b0, 7'd2, 1'b1, 1'b0, 1'b0, 1'b0), "stall_b3");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 32'h34, 1'b1, 7'd1, 1'b1, 1'b0, 1'b0, 1'b0), "stall_b4");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 32'h0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0), "stall_done");

    // Overflow: 66 writes, only the first 64 kept; then drain them as one frame.
    for (int i = 0; i < 66; i++)
      step(mk(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0,
              (i < 64) ? 7'(i) : 7'd64, 1'b0, 1'b0, (i >= 65), 1'b0), "ovf_push");
    step(mk(1'b0, 32'h0, 1'b1, 1'b0, 7'd64, 1'b0, 1'b0, 32'h0, 1'b0, 7'd64, 1'b0, 1'b0, 1'b1, 1'b0), "ovf_start");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 32'h0, 1'b0, 7'd64, 1'b1, 1'b0, 1'b1, 1'b0), "ovf_fill");
    for (int k = 0; k < 64; k++)
      step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 32'h100 + 32'(k), (k == 63), 7'(64 - k), 1'b1, 1'b0, 1'b1, 1'b0), "ovf_beat");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b1, 1'b0), "ovf_done");
    step(mk(1'b0, 32'h0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0), "ovf_clr");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0), "ovf_cleared");

    // Bad lengths 0 and 65, then a valid len=2 frame.
    step(mk(1'b0, 32'h0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0), "len0_start");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1), "len0_err");
    step(mk(1'b0, 32'h0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1), "len_clr");
    step(mk(1'b0, 32'h0, 1'b1, 1'b0, 7'd65, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0), "len65_start");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1), "len65_err");
    step(mk(1'b1, 32'h51, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1), "len2_push1");
    step(mk(1'b1, 32'h52, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd1, 1'b0, 1'b0, 1'b0, 1'b1), "len2_push2");
    step(mk(1'b0, 32'h0, 1'b1, 1'b0, 7'd2, 1'b0, 1'b0, 32'h0, 1'b0, 7'd2, 1'b0, 1'b0, 1'b0, 1'b1), "len2_start");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 32'h0, 1'b0, 7'd2, 1'b1, 1'b0, 1'b0, 1'b1), "len2_fill");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 32'h51, 1'b0, 7'd2, 1'b1, 1'b0, 1'b0, 1'b1), "len2_b1");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 32'h52, 1'b1, 7'd1, 1'b1, 1'b0, 1'b0, 1'b1), "len2_b2");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1), "len2_done");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1), "len2_idle");

    // Clear after beat 2 of a 4-beat frame, while beat 3 is stalled.
    for (int i = 0; i < 4; i++)
      step(mk(1'b1, 32'h61 + 32'(i), 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 32'h0, 1'b0, 7'(i), 1'b0, 1'b0, 1'b0, 1'b1), "abort_push");
    step(mk(1'b0, 32'h0, 1'b1, 1'b0, 7'd4, 1'b0, 1'b0, 32'h0, 1'b0, 7'd4, 1'b0, 1'b0, 1'b0, 1'b1), "abort_start");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 32'h0, 1'b0, 7'd4, 1'b1, 1'b0, 1'b0, 1'b1), "abort_fill");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 32'h61, 1'b0, 7'd4, 1'b1, 1'b0, 1'b0, 1'b1), "abort_b1");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 32'h62, 1'b0, 7'd3, 1'b1, 1'b0, 1'b0, 1'b1), "abort_b2");
    step(mk(1'b0, 32'h0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b1, 32'h63, 1'b0, 7'd2, 1'b1, 1'b0, 1'b0, 1'b1), "abort_clr");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0), "abort_after");
    step(mk(1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 32'h0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0), "abort_nodone");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
